// File: rtl/sync_spram_ext.sv
// Single-port synchronous SRAM with byte-lane write enables, selectable read-during-write
// behaviour, 1- or 2-cycle read latency with a valid strobe, and an optional post-reset clear.
module sync_spram_ext #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DATA_DEPTH    = 1024,
    parameter int                    BYTE_SIZE     = 8,
    parameter int                    READ_LATENCY  = 1,
    parameter string                 RW_MODE       = "READ_FIRST",
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [$clog2(DATA_DEPTH)-1:0]    addr_i,
    input  logic                             en_i,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  we_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    output logic                             ready_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             rvalid_o
);

    localparam int            AW             = $clog2(DATA_DEPTH);
    localparam int            LANES          = DATA_WIDTH / BYTE_SIZE;
    localparam logic [AW-1:0] LAST_ADDR      = AW'(DATA_DEPTH - 1);
    localparam bit            IS_WRITE_FIRST = (RW_MODE == "WRITE_FIRST");
    localparam bit            IS_NO_CHANGE   = (RW_MODE == "NO_CHANGE");

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "sync_spram_ext: READ_LATENCY must be 1 or 2");
    end
    if (RW_MODE != "READ_FIRST" && RW_MODE != "WRITE_FIRST" && RW_MODE != "NO_CHANGE") begin : g_bad_mode
        $fatal(1, "sync_spram_ext: RW_MODE must be READ_FIRST, WRITE_FIRST or NO_CHANGE");
    end
    if (DATA_WIDTH % BYTE_SIZE != 0) begin : g_bad_lanes
        $fatal(1, "sync_spram_ext: DATA_WIDTH must be a multiple of BYTE_SIZE");
    end
    if (DATA_DEPTH < 2 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_spram_ext: DATA_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic                   vld1_q, vld1_d;
    logic [DATA_WIDTH-1:0]  rdata1_q, rdata1_d;

    logic [DATA_WIDTH-1:0]  mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0]  old_word;
    logic [DATA_WIDTH-1:0]  merged_word;
    logic                   accept;
    logic                   is_write;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q    <= '0;
            vld1_q   <= 1'b0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld1_q   <= vld1_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        old_word    = mem[addr_i];
        merged_word = old_word;
        for (int k = 0; k < LANES; k++) begin
            if (we_i[k]) begin
                merged_word[k*BYTE_SIZE +: BYTE_SIZE] = wdata_i[k*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    // The clear sequence owns the array port in INIT; user requests only reach it in RUN.
    always_comb begin
        ready_o  = (state_q == ST_RUN);
        accept   = en_i & ready_o;
        is_write = |we_i;
        if (state_q == ST_INIT) begin
            mem_we    = ~rst;
            mem_addr  = cnt_q;
            mem_wdata = INIT_VALUE;
        end else begin
            mem_we    = accept & is_write & ~rst;
            mem_addr  = addr_i;
            mem_wdata = merged_word;
        end
        vld1_d   = accept & ~(IS_NO_CHANGE & is_write);
        rdata1_d = rdata1_q;
        if (vld1_d) begin
            rdata1_d = (is_write && IS_WRITE_FIRST) ? merged_word : old_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  vld2_q, vld2_d;
        logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;

        always_comb begin
            vld2_d   = vld1_q;
            rdata2_d = vld1_q ? rdata1_q : rdata2_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld2_q   <= 1'b0;
                rdata2_q <= '0;
            end else begin
                vld2_q   <= vld2_d;
                rdata2_q <= rdata2_d;
            end
        end

        assign rvalid_o = vld2_q;
        assign rdata_o  = rdata2_q;
    end else begin : g_lat1
        assign rvalid_o = vld1_q;
        assign rdata_o  = rdata1_q;
    end

endmodule

// File: tb/tb_sync_spram_ext.sv
// Bench for sync_spram_ext: three instances (READ_FIRST/L1/init, WRITE_FIRST/L2/init,
// NO_CHANGE/L1/no-init) share one stimulus stream and are checked against a word-level model.
module tb_sync_spram_ext;

    localparam int          DEP   = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] INITV = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [31:0] rd [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_spram_ext #(.DATA_WIDTH(32), .DATA_DEPTH(DEP), .BYTE_SIZE(8), .READ_LATENCY(1),
                     .RW_MODE("READ_FIRST"), .INIT_ON_RESET(1'b1), .INIT_VALUE(INITV)) u_rf (
        .clk(clk), .rst(rst), .addr_i(addr), .en_i(en), .we_i(we), .wdata_i(wdata),
        .ready_o(rdy[0]), .rdata_o(rd[0]), .rvalid_o(rv[0]));

    sync_spram_ext #(.DATA_WIDTH(32), .DATA_DEPTH(DEP), .BYTE_SIZE(8), .READ_LATENCY(2),
                     .RW_MODE("WRITE_FIRST"), .INIT_ON_RESET(1'b1), .INIT_VALUE(INITV)) u_wf (
        .clk(clk), .rst(rst), .addr_i(addr), .en_i(en), .we_i(we), .wdata_i(wdata),
        .ready_o(rdy[1]), .rdata_o(rd[1]), .rvalid_o(rv[1]));

    sync_spram_ext #(.DATA_WIDTH(32), .DATA_DEPTH(DEP), .BYTE_SIZE(8), .READ_LATENCY(1),
                     .RW_MODE("NO_CHANGE"), .INIT_ON_RESET(1'b0), .INIT_VALUE(INITV)) u_nc (
        .clk(clk), .rst(rst), .addr_i(addr), .en_i(en), .we_i(we), .wdata_i(wdata),
        .ready_o(rdy[2]), .rdata_o(rd[2]), .rvalid_o(rv[2]));

    // Model configuration per instance: mode 0=READ_FIRST 1=WRITE_FIRST 2=NO_CHANGE
    int lat   [3] = '{1, 2, 1};
    int mode  [3] = '{0, 1, 2};
    bit initr [3] = '{1'b1, 1'b1, 1'b0};

    logic [31:0] mm  [3][DEP];
    bit          mk  [3][DEP];
    int          init_left [3];
    int          ncyc = 0;
    bit          sv  [3][4];
    logic [31:0] sd  [3][4];
    bit          sdc [3][4];
    logic [31:0] held    [3];
    bit          held_dc [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic post(input int i, input logic [31:0] d, input bit dc);
        int s;
        s = (ncyc + lat[i] - 1) % 4;
        sv[i][s]  = 1'b1;
        sd[i][s]  = d;
        sdc[i][s] = dc;
    endtask

    // Word-level model: applies each edge's request to a plain array and schedules the response.
    initial begin
        logic [31:0] old, nw;
        bit          ok, nk;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    init_left[i] = initr[i] ? DEP : 0;
                    held[i]      = '0;
                    held_dc[i]   = 1'b0;
                    for (int s = 0; s < 4; s++) sv[i][s] = 1'b0;
                end
            end else begin
                ncyc++;
                for (int i = 0; i < 3; i++) begin
                    if (init_left[i] > 0) begin
                        mm[i][DEP - init_left[i]] = INITV;
                        mk[i][DEP - init_left[i]] = 1'b1;
                        init_left[i]--;
                    end else if (en) begin
                        old = mm[i][addr];
                        ok  = mk[i][addr];
                        if (we == 4'h0) begin
                            post(i, old, !ok);
                        end else begin
                            nw = old;
                            for (int k = 0; k < 4; k++)
                                if (we[k]) nw[k*8 +: 8] = wdata[k*8 +: 8];
                            nk = ok || (we == 4'hF);
                            mm[i][addr] = nw;
                            mk[i][addr] = nk;
                            if (mode[i] == 0)      post(i, old, !ok);
                            else if (mode[i] == 1) post(i, nw, !nk);
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    initial begin
        int  s;
        bit  ev;
        forever begin
            @(negedge clk);
            s = ncyc % 4;
            for (int i = 0; i < 3; i++) begin
                ev = sv[i][s];
                if (ev) begin
                    held[i]    = sd[i][s];
                    held_dc[i] = sdc[i][s];
                    sv[i][s]   = 1'b0;
                end
                chk($sformatf("cyc%0d inst%0d ready", ncyc, i), rdy[i], (init_left[i] == 0));
                chk($sformatf("cyc%0d inst%0d rvalid", ncyc, i), rv[i], ev);
                if (!held_dc[i])
                    chk($sformatf("cyc%0d inst%0d rdata", ncyc, i), rd[i], held[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input int a, input logic [31:0] d);
        en    = e;
        we    = w;
        addr  = AW'(a);
        wdata = d;
    endtask

    task automatic req(input logic e, input logic [3:0] w, input int a, input logic [31:0] d);
        drive(e, w, a, d);
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 0, 32'h0);
        step();
        step();
        chk("reset ready rf", rdy[0], 0);
        chk("reset ready wf", rdy[1], 0);
        chk("reset ready nc", rdy[2], 1);
        chk("reset rvalid", rv, 0);
        chk("reset rdata rf", rd[0], 0);
        chk("reset rdata wf", rd[1], 0);
        chk("reset rdata nc", rd[2], 0);

        // Release with reads held on: no-init instance accepts on edge 1, others clear
        rst = 1'b0;
        drive(1'b1, 4'h0, 0, 32'h0);
        step();
        chk("nc first accept", rv[2], 1);
        chk("rf busy edge1", rdy[0], 0);
        for (int c = 2; c <= DEP; c++) begin
            step();
            if (c == DEP - 1) chk("init ready before last edge", rdy[1:0], 0);
        end
        chk("init ready after last edge", rdy[1:0], 2'b11);

        for (int a = 0; a < DEP; a++) req(1'b1, 4'h0, a, 32'h0);
        chk("init word 15", rd[0], INITV);

        // Byte lanes
        req(1'b1, 4'hF, 5, 32'h1122_3344);
        chk("rf write returns old", rd[0], INITV);
        req(1'b1, 4'h5, 5, 32'hFFFF_FFFF);
        chk("rf 2nd write returns old", rd[0], 32'h1122_3344);
        chk("wf 1st write merged", rd[1], 32'h1122_3344);
        req(1'b1, 4'h0, 5, 32'h0);
        chk("byte lanes rf read", rd[0], 32'h11FF_33FF);
        chk("wf 2nd write merged", rd[1], 32'h11FF_33FF);
        chk("byte lanes nc read", rd[2], 32'h11FF_33FF);
        req(1'b0, 4'h0, 0, 32'h0);
        chk("byte lanes wf read", rd[1], 32'h11FF_33FF);

        // Read-during-write
        req(1'b1, 4'hF, 9, 32'h0000_0001);
        req(1'b1, 4'hF, 9, 32'h0000_0002);
        chk("rdw read_first", rd[0], 32'h1);
        chk("rdw no_change pulse", rv[2], 0);
        chk("rdw no_change hold", rd[2], 32'h11FF_33FF);
        req(1'b0, 4'h0, 0, 32'h0);
        chk("rdw write_first", rd[1], 32'h2);

        // Latency-2 throughput
        for (int i = 0; i < 4; i++) req(1'b1, 4'hF, i, 32'(100 + i));
        req(1'b0, 4'h0, 0, 32'h0);
        req(1'b0, 4'h0, 0, 32'h0);
        req(1'b1, 4'h0, 0, 32'h0);
        chk("l2 no pulse on accept edge", rv[1], 0);
        for (int i = 1; i < 4; i++) begin
            req(1'b1, 4'h0, i, 32'h0);
            chk($sformatf("l2 burst pulse %0d", i - 1), rv[1], 1);
            chk($sformatf("l2 burst data %0d", i - 1), rd[1], 32'(100 + i - 1));
        end
        req(1'b0, 4'h0, 0, 32'h0);
        chk("l2 burst pulse 3", rv[1], 1);
        chk("l2 burst data 3", rd[1], 32'd103);
        step();
        chk("l2 burst end", rv[1], 0);

        // Reset at init counter = 7
        rst = 1'b1;
        drive(1'b0, 4'h0, 0, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b1, 4'h0, 0, 32'h0);
        repeat (7) step();
        chk("nc pulsing before reset", rv[2], 1);
        rst = 1'b1;
        #1;
        chk("reset drops rvalid", rv, 0);
        chk("reset mid-init ready", rdy[0], 0);
        step();
        rst = 1'b0;
        for (int c = 1; c <= DEP; c++) begin
            step();
            if (c == DEP - 1) chk("init rerun still busy", rdy[0], 0);
        end
        chk("init rerun done", rdy[0], 1);
        req(1'b1, 4'h0, 2, 32'h0);
        chk("rerun cleared word", rd[0], INITV);

        // Reset with reads in flight
        req(1'b1, 4'h0, 1, 32'h0);
        req(1'b1, 4'h0, 2, 32'h0);
        chk("l2 read in flight", rv[1], 1);
        drive(1'b0, 4'h0, 0, 32'h0);
        rst = 1'b1;
        #1;
        chk("in-flight reset rvalid", rv, 0);
        chk("in-flight reset ready", rdy[1], 0);
        step();
        rst = 1'b0;
        repeat (DEP + 3) step();
        chk("final ready", rdy[1:0], 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
